// File: rtl/j17_pkg.sv
// Shared opcode constants, instruction field positions and FSM encoding
// for the fetch/decode control unit.
package j17_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_SETTLE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int OP1_HI  = 26;
  localparam int OP1_LO  = 24;
  localparam int IMM_BIT = 23;
  localparam int FLG_BIT = 22;
  localparam int FL1_BIT = 21;
  localparam int OP2_HI  = 20;
  localparam int OP2_LO  = 0;

  localparam logic [4:0] OPC_ALU_MAX = 5'd11;
  localparam logic [4:0] OPC_MOV     = 5'd12;
  localparam logic [4:0] OPC_BR_LO   = 5'd13;
  localparam logic [4:0] OPC_BR_HI   = 5'd19;
  localparam logic [4:0] OPC_STORE   = 5'd20;
  localparam logic [4:0] OPC_LOAD    = 5'd21;
  localparam logic [4:0] OPC_NOP_LO  = 5'd22;
  localparam logic [4:0] OPC_NOP_HI  = 5'd30;
  localparam logic [4:0] OPC_HALT    = 5'd31;

  typedef struct packed {
    logic [4:0]  alucode;
    logic [2:0]  op1;
    logic [20:0] op2;
    logic        imm;
    logic        flag;
    logic        flag1;
    logic        regen;
    logic [1:0]  ramen;
    logic [2:0]  pcctl;
    logic [1:0]  wcode;
    logic        illegal;
  } ctrl_t;

  function automatic logic [4:0] f_opcode(input logic [31:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/j17_decoder.sv
// Combinational opcode-to-control mapping; operand fields pass through
// untouched for every opcode.
module j17_decoder
  import j17_pkg::*;
(
  input  logic [31:0] i_ir,
  output ctrl_t       o_ctrl
);

  logic [4:0] w_opc;

  always_comb begin
    w_opc         = f_opcode(i_ir);
    o_ctrl        = '0;
    o_ctrl.op1    = i_ir[OP1_HI:OP1_LO];
    o_ctrl.op2    = i_ir[OP2_HI:OP2_LO];
    o_ctrl.imm    = i_ir[IMM_BIT];
    o_ctrl.flag   = i_ir[FLG_BIT];
    o_ctrl.flag1  = i_ir[FL1_BIT];
    unique case (1'b1)
      (w_opc <= OPC_ALU_MAX): begin
        o_ctrl.alucode = w_opc;
        o_ctrl.regen   = 1'b1;
      end
      (w_opc == OPC_MOV): begin
        o_ctrl.regen = 1'b1;
        o_ctrl.wcode = 2'd1;
      end
      (w_opc >= OPC_BR_LO && w_opc <= OPC_BR_HI): begin
        o_ctrl.pcctl = 3'(w_opc - OPC_MOV);
      end
      (w_opc == OPC_STORE): begin
        o_ctrl.ramen = 2'b01;
      end
      (w_opc == OPC_LOAD): begin
        o_ctrl.ramen = 2'b10;
        o_ctrl.regen = 1'b1;
      end
      (w_opc >= OPC_NOP_LO && w_opc <= OPC_NOP_HI): begin
        o_ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode/execute sequencer driving datapath controls;
// one instruction per FETCH-DECODE-EXEC-SETTLE round.
module fetch_decode
  import j17_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] PC,
  output logic [9:0]  instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr_data,
  input  logic        instr_ack,
  output logic [4:0]  alucode,
  output logic [2:0]  op1,
  output logic [20:0] op2,
  output logic        imControl,
  output logic        flag,
  output logic        flag1,
  output logic        regenable,
  output logic [1:0]  ramenable,
  output logic [2:0]  pcControl,
  output logic [1:0]  writecode,
  output logic        dp_step,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      r_state;
  logic [31:0] r_ir;
  logic [31:0] r_retired;
  ctrl_t       r_ctrl;
  logic        r_req;
  logic        r_step;
  logic        r_halt;
  ctrl_t       w_dec;
  logic        w_is_halt;

  j17_decoder u_dec (
    .i_ir   (r_ir),
    .o_ctrl (w_dec)
  );

  assign w_is_halt = (f_opcode(r_ir) == OPC_HALT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_ctrl    <= '0;
      r_retired <= '0;
      r_req     <= 1'b0;
      r_step    <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_ack) begin
            r_ir    <= instr_data;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_ctrl  <= w_dec;
          r_step  <= !w_is_halt;
          r_halt  <= w_is_halt;
          r_state <= w_is_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          r_retired <= r_retired + 32'd1;
          r_step    <= 1'b0;
          r_state   <= S_SETTLE;
        end
        S_SETTLE: begin
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_step is high exactly during EXEC, so it doubles as the write gate
  assign instr_req  = r_req;
  assign instr_addr = r_req ? PC[9:0] : 10'd0;
  assign dp_step    = r_step;
  assign halted     = r_halt;
  assign retired    = r_retired;
  assign regenable  = r_ctrl.regen & r_step;
  assign ramenable  = r_ctrl.ramen & {2{r_step}};
  assign alucode    = r_ctrl.alucode;
  assign op1        = r_ctrl.op1;
  assign op2        = r_ctrl.op2;
  assign imControl  = r_ctrl.imm;
  assign flag       = r_ctrl.flag;
  assign flag1      = r_ctrl.flag1;
  assign pcControl  = r_ctrl.pcctl;
  assign writecode  = r_ctrl.wcode;
  assign illegal    = r_ctrl.illegal;

endmodule
